// File: rtl/ctrl_mat_mult_gen.sv
// ctrl_mat_mult_gen: sequences C[MxN] = A[MxK]*B[KxN] on a MAC array, one term per cycle.
// Define CTRL_STALL_COUNT_EN to add the stall_count output.
module ctrl_mat_mult_gen #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 8,
  parameter int PIPE_LAT = 1,
  parameter int CNT_W = 16,
  localparam int AW = (M * K > 1) ? $clog2(M * K) : 1,
  localparam int BW = (K * N > 1) ? $clog2(K * N) : 1,
  localparam int OW = (M * N > 1) ? $clog2(M * N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  output logic             load,
  output logic             mac_clr,
  output logic [AW-1:0]    a_addr,
  output logic [BW-1:0]    b_addr,
  output logic             wire_out,
  output logic [OW-1:0]    out_addr,
  output logic             busy,
  output logic             done,
`ifdef CTRL_STALL_COUNT_EN
  output logic [CNT_W-1:0] clock_count,
  output logic [CNT_W-1:0] stall_count
`else
  output logic [CNT_W-1:0] clock_count
`endif
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam logic [RW-1:0] ROW_L = RW'(M - 1);
  localparam logic [CW-1:0] COL_L = CW'(N - 1);
  localparam logic [KW-1:0] K_L = KW'(K - 1);
  localparam logic [DW-1:0] D_L = DW'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [1:0]       r_st;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [KW-1:0]    r_k;
  logic [DW-1:0]    r_dcnt;
  logic [CNT_W-1:0] r_cc;
  logic             r_pv [PIPE_LAT];
  logic [OW-1:0]    r_pa [PIPE_LAT];
  logic             w_k_end, w_col_end, w_last, w_inj;
  logic [CNT_W-1:0] w_cc_inc;

  assign w_k_end   = r_k == K_L;
  assign w_col_end = r_col == COL_L;
  assign w_last    = w_k_end && w_col_end && r_row == ROW_L;
  assign w_cc_inc  = (r_cc == C_MAX) ? r_cc : r_cc + 1'b1;
  assign load      = r_st == S_RUN && en;
  assign mac_clr   = load && r_k == '0;
  assign w_inj     = load && w_k_end;
  assign a_addr    = AW'(32'(r_row) * K + 32'(r_k));
  assign b_addr    = BW'(32'(r_k) * N + 32'(r_col));
  assign busy      = r_st == S_RUN || r_st == S_DRAIN;
  assign done      = r_st == S_DONE;
  assign clock_count = r_cc;
  assign wire_out  = r_pv[PIPE_LAT-1];
  assign out_addr  = r_pa[PIPE_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st   <= S_IDLE;
      r_row  <= '0;
      r_col  <= '0;
      r_k    <= '0;
      r_dcnt <= '0;
      r_cc   <= '0;
    end else begin
      case (r_st)
        S_IDLE: if (start) begin
          r_st  <= S_RUN;
          r_row <= '0;
          r_col <= '0;
          r_k   <= '0;
          r_cc  <= '0;
        end
        S_RUN: begin
          r_cc <= w_cc_inc;
          if (en) begin
            r_k <= w_k_end ? '0 : r_k + 1'b1;
            if (w_k_end) r_col <= w_col_end ? '0 : r_col + 1'b1;
            if (w_k_end && w_col_end) r_row <= r_row + 1'b1;
            if (w_last) begin
              r_st   <= S_DRAIN;
              r_dcnt <= D_L;
            end
          end
        end
        S_DRAIN: begin
          r_cc <= w_cc_inc;
          if (r_dcnt == '0) r_st <= S_DONE;
          else r_dcnt <= r_dcnt - 1'b1;
        end
        default: if (!start) r_st <= S_IDLE;
      endcase
    end
  end

  // Result tags ride alongside the MAC pipeline; cleared on reset so aborted terms never write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_inj;
      r_pa[0] <= OW'(32'(r_row) * N + 32'(r_col));
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

`ifdef CTRL_STALL_COUNT_EN
  logic [CNT_W-1:0] r_sc;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sc <= '0;
    else if (r_st == S_IDLE && start) r_sc <= '0;
    else if (r_st == S_RUN && !en && r_sc != C_MAX) r_sc <= r_sc + 1'b1;
  end
  assign stall_count = r_sc;
`endif
endmodule

// File: tb/tb_ctrl_mat_mult_gen.sv
// tb_ctrl_mat_mult_gen: three configurations checked cycle by cycle against a term-index model.
module tb_ctrl_mat_mult_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, en = 1'b1;
  always #5 clk = ~clk;

  logic l0, c0, w0, bz0, d0;
  logic [4:0] a0, b0;
  logic [3:0] o0;
  logic [15:0] cc0, sc0;
  logic l1, c1, w1, bz1, d1;
  logic [0:0] a1;
  logic [1:0] b1;
  logic [2:0] o1;
  logic [15:0] cc1, sc1;
  logic l2, c2, w2, bz2, d2;
  logic [2:0] a2, b2;
  logic [1:0] o2;
  logic [3:0] cc2, sc2;

  ctrl_mat_mult_gen u0 (.clk(clk), .reset(reset), .start(start), .en(en), .load(l0), .mac_clr(c0),
    .a_addr(a0), .b_addr(b0), .wire_out(w0), .out_addr(o0), .busy(bz0), .done(d0),
`ifdef CTRL_STALL_COUNT_EN
    .stall_count(sc0),
`endif
    .clock_count(cc0));

  ctrl_mat_mult_gen #(.M(2), .N(3), .K(1), .PIPE_LAT(3)) u1 (.clk(clk), .reset(reset), .start(start),
    .en(en), .load(l1), .mac_clr(c1), .a_addr(a1), .b_addr(b1), .wire_out(w1), .out_addr(o1),
    .busy(bz1), .done(d1),
`ifdef CTRL_STALL_COUNT_EN
    .stall_count(sc1),
`endif
    .clock_count(cc1));

  ctrl_mat_mult_gen #(.M(2), .N(2), .K(4), .PIPE_LAT(2), .CNT_W(4)) u2 (.clk(clk), .reset(reset),
    .start(start), .en(en), .load(l2), .mac_clr(c2), .a_addr(a2), .b_addr(b2), .wire_out(w2),
    .out_addr(o2), .busy(bz2), .done(d2),
`ifdef CTRL_STALL_COUNT_EN
    .stall_count(sc2),
`endif
    .clock_count(cc2));

`ifndef CTRL_STALL_COUNT_EN
  assign sc0 = '0;
  assign sc1 = '0;
  assign sc2 = '0;
`endif

  int sel;
  int g_load, g_clr, g_a, g_b, g_wire, g_oaddr, g_busy, g_done, g_cc, g_sc;
  always_comb begin
    case (sel)
      1: begin
        g_load = int'(l1); g_clr = int'(c1); g_a = int'(a1); g_b = int'(b1); g_wire = int'(w1);
        g_oaddr = int'(o1); g_busy = int'(bz1); g_done = int'(d1); g_cc = int'(cc1); g_sc = int'(sc1);
      end
      2: begin
        g_load = int'(l2); g_clr = int'(c2); g_a = int'(a2); g_b = int'(b2); g_wire = int'(w2);
        g_oaddr = int'(o2); g_busy = int'(bz2); g_done = int'(d2); g_cc = int'(cc2); g_sc = int'(sc2);
      end
      default: begin
        g_load = int'(l0); g_clr = int'(c0); g_a = int'(a0); g_b = int'(b0); g_wire = int'(w0);
        g_oaddr = int'(o0); g_busy = int'(bz0); g_done = int'(d0); g_cc = int'(cc0); g_sc = int'(sc0);
      end
    endcase
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cfg %0d, t=%0t)", tag, act, exp, sel, $time);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 drain, 3 done; j is the index of the next term to issue.
  int m_m, m_n, m_k, m_p, m_cw;
  int m_st, m_j, m_dr, m_cc, m_sc, m_rc, m_t;
  int wq_t[$], wq_a[$];

  task automatic set_cfg(input int s);
    sel = s;
    m_m = (s == 0) ? 4 : 2;
    m_n = (s == 1) ? 3 : (s == 2) ? 2 : 4;
    m_k = (s == 1) ? 1 : (s == 2) ? 4 : 8;
    m_p = (s == 1) ? 3 : (s == 2) ? 2 : 1;
    m_cw = (s == 2) ? 4 : 16;
  endtask

  task automatic model_reset();
    m_st = 0; m_j = 0; m_dr = 0; m_cc = 0; m_sc = 0; m_rc = 0;
    wq_t.delete();
    wq_a.delete();
  endtask

  function automatic int sat(input int v);
    return (v < (1 << m_cw) - 1) ? v + 1 : v;
  endfunction

  task automatic step();
    int row, col, k;
    bit el, wexp;
    #1;
    el = (m_st == 1) && en;
    check("load", g_load, int'(el));
    check("mac_clr", g_clr, int'(el && (m_j % m_k == 0)));
    if (el) begin
      row = m_j / (m_n * m_k);
      col = (m_j / m_k) % m_n;
      k = m_j % m_k;
      check("a_addr", g_a, row * m_k + k);
      check("b_addr", g_b, k * m_n + col);
    end
    check("busy", g_busy, int'(m_st == 1 || m_st == 2));
    check("done", g_done, int'(m_st == 3));
    wexp = wq_t.size() > 0 && wq_t[0] == m_t;
    check("wire_out", g_wire, int'(wexp));
    if (wexp) begin
      check("out_addr", g_oaddr, wq_a[0]);
      void'(wq_t.pop_front());
      void'(wq_a.pop_front());
    end
    check("clock_count", g_cc, m_cc);
`ifdef CTRL_STALL_COUNT_EN
    check("stall_count", g_sc, m_sc);
`endif
    if (reset) model_reset();
    else begin
      case (m_st)
        0: if (start) begin m_st = 1; m_j = 0; m_cc = 0; m_sc = 0; m_rc = 0; end
        1: begin
          m_cc = sat(m_cc);
          m_rc++;
          if (en) begin
            if (m_j % m_k == m_k - 1) begin
              wq_t.push_back(m_t + m_p);
              wq_a.push_back(m_j / m_k);
            end
            m_j++;
            if (m_j == m_m * m_n * m_k) begin m_st = 2; m_dr = m_p; end
          end else m_sc = sat(m_sc);
        end
        2: begin
          m_cc = sat(m_cc);
          m_rc++;
          m_dr--;
          if (m_dr == 0) m_st = 3;
        end
        default: if (!start) m_st = 0;
      endcase
    end
    m_t++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; en = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    step();
  endtask

  // mode 0: en held; 1: en low for RUN cycles 7..9; 2: random en. abort_at: RUN cycle to reset at.
  task automatic run_job(input int mode, input int abort_at, input bit hold, input int exp_cc);
    int n = 0;
    start = 1'b1;
    en = 1'b1;
    do begin
      if (m_st == 1 && m_rc == abort_at) begin
        reset = 1'b1; start = 1'b0;
        model_reset();
        step();
        reset = 1'b0;
        repeat (4) step();
        return;
      end
      en = (mode == 0) ? 1'b1 : (mode == 1) ? !(m_st == 1 && m_rc >= 7 && m_rc <= 9)
         : ($urandom_range(0, 3) != 0);
      start = (m_st == 0 || hold) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      n++;
    end while (m_st != 3 && n < 3000);
    if (n >= 3000) check("timeout", 0, 1);
    #1;
    if (exp_cc >= 0) check("job_clock_count", g_cc, exp_cc);
    if (hold) begin
      start = 1'b1;
      repeat (4) step();
    end
    start = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    set_cfg(0);
    model_reset();
    m_t = 0;
    @(negedge clk);
    do_reset();
    run_job(0, -1, 1'b0, 129);
    run_job(1, -1, 1'b0, 132);
    run_job(2, -1, 1'b0, -1);
    run_job(0, 50, 1'b0, -1);
    run_job(0, -1, 1'b0, 129);
    set_cfg(1);
    do_reset();
    run_job(0, -1, 1'b0, 9);
    run_job(2, -1, 1'b0, -1);
    set_cfg(2);
    do_reset();
    run_job(0, -1, 1'b1, 15);
    run_job(2, -1, 1'b0, 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
